// File: rtl/resp_line_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resp_line_unpacker_pkg
// Description : Shared constants, state encoding and the length-clamp helper
//               for the response-line unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
package resp_line_unpacker_pkg;

    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_W         = 32;
    localparam int PTR_W          = 3;   // selects one of WORDS_PER_LINE words
    localparam int REM_W          = 4;   // holds 0..WORDS_PER_LINE

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // A request longer than one line would only revisit words already sent,
    // so the count is saturated at the number of words in a line.
    function automatic logic [REM_W-1:0] clamp_len(input logic [31:0] len);
        if (len > 32'(WORDS_PER_LINE)) begin
            return REM_W'(WORDS_PER_LINE);
        end
        return len[REM_W-1:0];
    endfunction

endpackage : resp_line_unpacker_pkg
`default_nettype wire

// File: rtl/resp_data_get.sv
`default_nettype none
// ============================================================================
// Module      : resp_data_get
// Description : N:1 word-select mux over a packed line. Word k occupies
//               in[k*WORD_W +: WORD_W].
//   Ports     : in     - packed line (N*WORD_W bits)
//               in_num - index of the word to select
//               out    - selected word
// Revision    : 1.0 - initial release
// ============================================================================
module resp_data_get #(
    parameter int WORD_W = 32,
    parameter int N      = 8
) (
    input  logic [N*WORD_W-1:0]  in,
    input  logic [$clog2(N)-1:0] in_num,
    output logic [WORD_W-1:0]    out
);

    logic [WORD_W-1:0] w_words [N];

    for (genvar k = 0; k < N; k++) begin : g_word
        assign w_words[k] = in[k*WORD_W +: WORD_W];
    end

    assign out = w_words[in_num];

endmodule : resp_data_get
`default_nettype wire

// File: rtl/resp_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : resp_line_unpacker
// Description : Accepts one response line with a start word and word count,
//               then emits the selected words one per handshake, wrapping the
//               word pointer 7->0 and flagging the final word.
//   Ports     : clk, rst_n                       - clock, async active-low reset
//               in_valid/in_ready/in_data/
//               in_start/in_len                  - line request channel
//               out_valid/out_ready/out_data/
//               out_idx/out_last                 - word output channel
//               busy                             - a line is being drained
// Revision    : 1.0 - initial release
// ============================================================================
import resp_line_unpacker_pkg::*;

module resp_line_unpacker #(
    parameter int LINE_W = 256,
    parameter int WORD_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LINE_W-1:0] in_data,
    input  logic [2:0]        in_start,
    input  logic [LEN_W-1:0]  in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [2:0]        out_idx,
    output logic              out_last,
    output logic              busy
);

    logic [0:0]        state_q,     state_d;
    logic [PTR_W-1:0]  ptr_q,       ptr_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic [LINE_W-1:0] line_q,      line_d;

    logic w_drain;
    logic w_out_hs;
    logic w_last_hs;
    logic w_accept;

    assign w_drain   = (state_q == ST_DRAIN);
    assign out_valid = w_drain;
    assign busy      = w_drain;
    assign out_idx   = ptr_q;
    assign out_last  = w_drain && (remaining_q == REM_W'(1));

    assign w_out_hs  = out_valid & out_ready;
    assign w_last_hs = w_out_hs & out_last;

    // Ready while idle, and also on the last handshake so the next line can
    // be loaded without a bubble (combinational out_ready -> in_ready path).
    assign in_ready  = ~w_drain | w_last_hs;
    assign w_accept  = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        line_d      = line_q;

        if (w_accept) begin
            // An accept takes priority: it either starts a fresh line or, when
            // it coincides with the last handshake, replaces the finished one.
            if (in_len == '0) begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end else begin
                state_d     = ST_DRAIN;
                line_d      = in_data;
                ptr_d       = in_start;
                remaining_d = clamp_len(32'(in_len));
            end
        end else if (w_out_hs) begin
            if (out_last) begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end else begin
                ptr_d       = ptr_q + PTR_W'(1);
                remaining_d = remaining_q - REM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            line_q      <= line_d;
        end
    end

    resp_data_get #(
        .WORD_W (WORD_W),
        .N      (WORDS_PER_LINE)
    ) u_word_mux (
        .in     (line_q),
        .in_num (ptr_q),
        .out    (out_data)
    );

endmodule : resp_line_unpacker
`default_nettype wire

// File: tb/tb_resp_line_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_line_unpacker
// Description : Directed, table-driven bench for resp_line_unpacker. Inputs
//               change on the falling edge; outputs are sampled on the
//               falling edge, half a cycle away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_line_unpacker;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [2:0]   in_start;
    logic [3:0]   in_len;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         busy;

    int n_vec;
    int n_err;

    resp_line_unpacker #(
        .LINE_W (256),
        .WORD_W (32),
        .LEN_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_start  (in_start),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One line request plus the hand-written word order it must produce.
    // seq holds the expected indices, nibble k = k-th emitted word.
    typedef struct {
        logic [2:0]  start;
        logic [3:0]  len;
        logic [31:0] base;
        int          n;
        logic [31:0] seq;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    // Present a line at the falling edge; it is accepted on the next rising edge.
    task automatic send_line(input logic [2:0] s, input logic [3:0] len, input logic [31:0] base);
        @(negedge clk);
        check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_data  = make_line(base);
        in_start = s;
        in_len   = len;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '1;      // later changes must be ignored
        in_start = 3'd0;
        in_len   = 4'd0;
    endtask

    // Expect one word on the current falling edge: {valid, last, idx, data}.
    task automatic expect_word(input string name, input logic [3:0] idx,
                               input logic [31:0] data, input logic last);
        check(name, {27'd0, out_valid, out_last, busy, out_idx, out_data},
                    {27'd0, 1'b1, last, 1'b1, idx[2:0], data});
    endtask

    task automatic expect_idle(input string name);
        check(name, {61'd0, out_valid, busy, in_ready}, {61'd0, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_start  = 3'd0;
        in_len    = 4'd0;
        out_ready = 1'b1;

        //             start  len    base          n  seq
        vecs[0] = '{3'd0, 4'd8,  32'h0000_00A0, 8, 32'h7654_3210};
        vecs[1] = '{3'd6, 4'd4,  32'h0000_0100, 4, 32'h0000_1076};
        vecs[2] = '{3'd3, 4'd12, 32'h0000_0200, 8, 32'h2107_6543};
        vecs[3] = '{3'd5, 4'd0,  32'h0000_0300, 0, 32'h0000_0000};
        vecs[4] = '{3'd7, 4'd1,  32'h0000_0400, 1, 32'h0000_0007};
        vecs[5] = '{3'd2, 4'd15, 32'h0000_0500, 8, 32'h1076_5432};
        vecs[6] = '{3'd4, 4'd8,  32'h0000_0600, 8, 32'h3210_7654};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {57'd0, out_valid, out_last, busy, in_ready, out_idx},
                             {57'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        check("reset_out_data", {32'd0, out_data}, 64'd0);
        rst_n = 1'b1;

        // Table-driven lines, out_ready held high: one word per cycle.
        for (int v = 0; v < 7; v++) begin
            send_line(vecs[v].start, vecs[v].len, vecs[v].base);
            for (int k = 0; k < vecs[v].n; k++) begin
                logic [3:0] e;
                e = vecs[v].seq[4*k +: 4];
                @(negedge clk);
                expect_word($sformatf("vec%0d_word%0d", v, k), e,
                            vecs[v].base + {28'd0, e}, (k == vecs[v].n - 1));
            end
            @(negedge clk);
            expect_idle($sformatf("vec%0d_done", v));
        end

        // Stall on the second word for 3 cycles.
        send_line(3'd0, 4'd3, 32'h0000_0700);
        @(negedge clk);
        expect_word("stall_w0", 4'd0, 32'h0000_0700, 1'b0);
        @(negedge clk);
        expect_word("stall_w1", 4'd1, 32'h0000_0701, 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            expect_word($sformatf("stall_hold%0d", c), 4'd1, 32'h0000_0701, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        expect_word("stall_w2", 4'd2, 32'h0000_0702, 1'b1);
        @(negedge clk);
        expect_idle("stall_done");

        // Back-to-back: B offered during A's last handshake, then a len=0
        // line offered during B's last handshake.
        send_line(3'd0, 4'd2, 32'h0000_0800);
        @(negedge clk);
        expect_word("b2b_a0", 4'd0, 32'h0000_0800, 1'b0);
        @(negedge clk);
        expect_word("b2b_a1", 4'd1, 32'h0000_0801, 1'b1);
        check("b2b_in_ready_on_last", {63'd0, in_ready}, 64'd1);
        in_data  = make_line(32'h0000_0900);
        in_start = 3'd5;
        in_len   = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        expect_word("b2b_b0", 4'd5, 32'h0000_0905, 1'b0);
        @(negedge clk);
        expect_word("b2b_b1", 4'd6, 32'h0000_0906, 1'b1);
        in_data  = make_line(32'h0000_0A00);
        in_start = 3'd1;
        in_len   = 4'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        expect_idle("b2b_len0_idle");

        // Mid-drain reset after 2 of 5 words.
        send_line(3'd1, 4'd5, 32'h0000_0B00);
        @(negedge clk);
        expect_word("rst_w0", 4'd1, 32'h0000_0B01, 1'b0);
        @(negedge clk);
        expect_word("rst_w1", 4'd2, 32'h0000_0B02, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async", {61'd0, out_valid, busy, out_last}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_after%0d", c),
                  {29'd0, out_valid, busy, in_ready, out_idx, out_data},
                  {29'd0, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_resp_line_unpacker
`default_nettype wire
